// File: rtl/generic_demux1x2_stream.sv
// Registered 1-to-2 valid/ready stream demux, 2-entry buffer per output.
// Optional per-output delivery counters: `define DEMUX_COUNT_EN.
module generic_demux1x2_stream #(
  parameter int n     = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  input  logic         sel,
  output logic         in_ready,
  output logic [n-1:0] f0_data,
  output logic         f0_valid,
  input  logic         f0_ready,
  output logic [n-1:0] f1_data,
  output logic         f1_valid,
  input  logic         f1_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] f0_count,
  output logic [CNT_W-1:0] f1_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e         st_q [2];
  occ_e         st_d [2];
  logic [n-1:0] head_q [2];
  logic [n-1:0] tail_q [2];
  logic [1:0]   push;
  logic [1:0]   pop;
  logic [1:0]   vld;
  logic [1:0]   rdy;
  logic         acc;

  // Input may enter unless the selected buffer is full
  always_comb begin
    in_ready = 1'b0;
    if (resetn) begin
      in_ready = sel ? (st_q[1] != TWO)
                     : (st_q[0] != TWO);
    end
  end

  // Push/pop strobes for both buffers
  always_comb begin
    acc     = in_valid & in_ready;
    push[0] = acc & ~sel;
    push[1] = acc & sel;
    rdy     = {f1_ready, f0_ready};
    vld[0]  = (st_q[0] != EMPTY);
    vld[1]  = (st_q[1] != EMPTY);
    pop     = vld & rdy;
  end

  // Occupancy next-state for each buffer
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k] = st_q[k];
      unique case (st_q[k])
        EMPTY: begin
          if (push[k]) st_d[k] = ONE;
        end
        ONE: begin
          if (push[k] && !pop[k])
            st_d[k] = TWO;
          else if (pop[k] && !push[k])
            st_d[k] = EMPTY;
        end
        TWO: begin
          if (pop[k]) st_d[k] = ONE;
        end
        default: st_d[k] = EMPTY;
      endcase
    end
  end

  // Occupancy state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++)
        st_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 2; k++)
        st_q[k] <= st_d[k];
    end
  end

  // Head/tail storage; head is always the oldest word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        unique case (st_q[k])
          EMPTY: begin
            if (push[k]) head_q[k] <= in_data;
          end
          ONE: begin
            if (push[k] && pop[k])
              head_q[k] <= in_data;
            else if (push[k])
              tail_q[k] <= in_data;
          end
          TWO: begin
            if (pop[k]) head_q[k] <= tail_q[k];
          end
          default: ;
        endcase
      end
    end
  end

  assign f0_data  = head_q[0];
  assign f1_data  = head_q[1];
  assign f0_valid = vld[0];
  assign f1_valid = vld[1];

`ifdef DEMUX_COUNT_EN
  // Saturating delivery counters, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f0_count <= '0;
      f1_count <= '0;
    end else begin
      if (pop[0] && (f0_count != '1))
        f0_count <= f0_count + 1'b1;
      if (pop[1] && (f1_count != '1))
        f1_count <= f1_count + 1'b1;
    end
  end
`endif

endmodule
